// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: pixel-clock timing generator for a parallel RGB LCD panel.
// Issues framebuffer read requests one cycle ahead of the framebuffer's
// one-cycle read latency, and presents de/hsync_n/vsync_n/rgb_out two cycles
// after the request so that data and control leave the block together.
//
// Handshake: req_valid is a one-cycle request with no back-pressure. The
// framebuffer must return the pixel for (req_x, req_y) on rgb_in in the very
// next cycle. rgb_in is ignored in every other cycle.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        req_valid,
  output logic [9:0]  req_x,
  output logic [8:0]  req_y,
  input  logic [23:0] rgb_in,
  output logic [23:0] rgb_out,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // All compare points are inclusive so that none of them can exceed the
  // counter range, even when a porch is zero or the total is a power of two.
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            locked_m;
  logic            locked_s;
  logic            active;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            pix_on;
  logic            hs_on;
  logic            vs_on;
  logic            hs_p1;
  logic            vs_p1;
  logic            de_p2;
  logic            hs_p2;
  logic            vs_p2;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state. The raster starts moving in the same cycle IDLE sees
  // lock, so pixel (0,0) is requested as the FSM enters RUN; losing lock
  // stops and flushes everything in the cycle the FSM leaves RUN.
  always_comb begin
    next_state = state;
    active     = 1'b0;
    case (state)
      IDLE: begin
        active = locked_s;
        if (locked_s) next_state = RUN;
      end
      RUN: begin
        active = locked_s;
        if (!locked_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Raster position decode from the counters.
  always_comb begin
    pix_on = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
    hs_on  = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
    vs_on  = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
  end

  // Horizontal and vertical counters; held at zero while not active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!active) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 1: registered read request plus sync flags of the same pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      frame_start <= 1'b0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
    end else if (!active) begin
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      frame_start <= 1'b0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
    end else begin
      req_valid   <= pix_on;
      req_x       <= pix_on ? 10'(h_cnt) : 10'd0;
      req_y       <= pix_on ? 9'(v_cnt) : 9'd0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hs_p1       <= hs_on;
      vs_p1       <= vs_on;
    end
  end

  // Stage 2: wait out the framebuffer read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_p2 <= 1'b0;
      hs_p2 <= 1'b0;
      vs_p2 <= 1'b0;
    end else if (!active) begin
      de_p2 <= 1'b0;
      hs_p2 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      de_p2 <= req_valid;
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
    end
  end

  // Stage 3: panel outputs; returned data is captured only for active pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de      <= 1'b0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      rgb_out <= '0;
    end else if (!active) begin
      de      <= 1'b0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      rgb_out <= '0;
    end else begin
      de      <= de_p2;
      hsync_n <= ~hs_p2;
      vsync_n <= ~vs_p2;
      rgb_out <= de_p2 ? rgb_in : 24'h0;
    end
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE, 480, visible pixels per line.
- H_FP, 2, horizontal front porch in pixel clocks.
- H_SYNC, 41, hsync pulse width in pixel clocks.
- H_BP, 2, horizontal back porch in pixel clocks.
- V_ACTIVE, 272, visible lines per frame.
- V_FP, 2, vertical front porch in lines.
- V_SYNC, 10, vsync pulse width in lines.
- V_BP, 2, vertical back porch in lines.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, 9 MHz pixel clock from the PLL second output. This is the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- pll_locked, in, 1, PLL lock flag, asynchronous to clk.
- req_valid, out, 1, framebuffer read request for one pixel.
- req_x, out, 10, pixel column of the request.
- req_y, out, 9, pixel row of the request.
- rgb_in, in, 24, framebuffer data, valid in the cycle after req_valid.
- rgb_out, out, 24, pixel data to the panel.
- de, out, 1, panel data enable.
- hsync_n, out, 1, horizontal sync, active low.
- vsync_n, out, 1, vertical sync, active low.
- frame_start, out, 1, one-cycle pulse marking the start of a frame.

Function
REQ-003 pll_locked SHALL pass through a 2-flop synchroniser before use (locked_s).
REQ-004 State machine states SHALL be IDLE and RUN.
- IDLE -> RUN when locked_s=1.
- RUN -> IDLE in the cycle after locked_s=0.
REQ-005 In IDLE: counters held at 0, req_valid=0, de=0, hsync_n=1, vsync_n=1, rgb_out=0, frame_start=0.
REQ-006 In RUN, h_cnt SHALL count 0..H_TOTAL-1 and then wrap to 0, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (525 by default).
REQ-007 v_cnt SHALL increment when h_cnt wraps, and SHALL wrap to 0 after V_TOTAL-1, where V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (286 by default).
REQ-008 Horizontal line order SHALL be: active 0..479, front porch 480..481, sync 482..522, back porch 523..524. Vertical frame order SHALL be the same pattern: active 0..271, front porch 272..273, sync 274..283, back porch 284..285.
REQ-009 req_valid, req_x and req_y SHALL be registered. In cycle T they reflect the counters; req_valid=1 only when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. req_x=h_cnt and req_y=v_cnt in that case, and both are 0 otherwise.
REQ-010 de, hsync_n and vsync_n SHALL be delayed two cycles relative to req_*, so that the pixel requested in T is displayed in T+2.
REQ-011 rgb_out SHALL be registered from rgb_in at the end of T+1 when the delayed req_valid=1, and SHALL be 0 whenever de=0.
REQ-012 hsync_n=0 SHALL cover exactly H_SYNC consecutive clocks per line. vsync_n=0 SHALL cover exactly V_SYNC whole lines, with edges aligned to the hsync-pipeline start of line (h_cnt=0 delayed by 2).
REQ-013 frame_start SHALL pulse for one cycle, coincident with req_valid for pixel (0,0).
REQ-014 Loss of lock mid-frame: all outputs SHALL reach their idle values within 4 clk of pll_locked falling, and the pipeline SHALL be flushed with no partial pixel emitted. On relock, output SHALL restart at pixel (0,0) with frame_start.
REQ-015 All counter widths SHALL hold H_TOTAL-1 and V_TOTAL-1 without overflow. Compare logic SHALL use parameters only, with no hard-coded constants.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE, clear the synchroniser, clear the counters and the pipeline, and drive the REQ-005 output values. Release SHALL be synchronous to clk.
REQ-017 Reset asserted mid-line SHALL yield no glitch on hsync_n or vsync_n, which are driven high immediately.

Verification
REQ-018 Reset released, pll_locked=1 -> first frame_start within 3 clk. req_valid=1 with req_x=0, req_y=0 in that cycle, and de=1 two cycles later.
REQ-019 One full frame -> exactly 130560 de-high cycles (480x272) in 150150 clk (525x286). hsync_n low 41 clk per line, vsync_n low 10 lines.
REQ-020 Framebuffer model returns rgb_in = {req_y[7:0], req_x[9:0], 6'h0} with 1-cycle latency -> rgb_out for every de cycle matches that value at the matching position, and rgb_out=0 during blanking.
REQ-021 pll_locked dropped at pixel (100,50) -> de=0, hsync_n=1, vsync_n=1 within 4 clk. Relock -> restart at (0,0) with frame_start.
REQ-022 rst_n pulsed low mid-vsync -> outputs idle the same cycle, and a clean frame restarts after release.
REQ-023 Line and frame boundaries -> h_cnt 524->0 increments v_cnt. Pixel (479,271) is followed by blanking, then (0,0) of the next frame.
